// File: rtl/fm0_acsu.sv
// FM0 add-compare-select unit: two-stage ACS with path-metric normalization,
// input-spacing enforcement, frame restart and overrun detection.
module fm0_acsu #(
   parameter int METRIC_WIDTH = 10,
   parameter int BM_WIDTH     = 6,
   parameter int NUM_STATES   = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             bm_vld,
   input  logic [NUM_STATES*BM_WIDTH-1:0]   bm_in,
   input  logic                             frame_start,
   input  logic [NUM_STATES*METRIC_WIDTH-1:0] pm_in,
   output logic [NUM_STATES*METRIC_WIDTH-1:0] pm_new,
   output logic                             pm_vld,
   output logic [NUM_STATES-1:0]            dec,
   output logic                             dec_vld,
   output logic [1:0]                       best_state,
   output logic [15:0]                      sym_cnt,
   output logic                             overrun
);

   localparam int SW = METRIC_WIDTH + 1;
   localparam logic [SW-1:0] HALF = SW'(1) << (METRIC_WIDTH - 1);
   localparam logic [METRIC_WIDTH-1:0] MAXV = '1;

   logic [1:0]              busy;
   logic                    fresh;
   logic                    s1_vld;
   logic                    accept;
   logic                    emit;
   logic [METRIC_WIDTH-1:0] pm_use   [NUM_STATES];
   logic [SW-1:0]           cand_a_d [NUM_STATES];
   logic [SW-1:0]           cand_b_d [NUM_STATES];
   logic [SW-1:0]           cand_a   [NUM_STATES];
   logic [SW-1:0]           cand_b   [NUM_STATES];
   logic [SW-1:0]           surv     [NUM_STATES];
   logic [SW-1:0]           norm     [NUM_STATES];
   logic [METRIC_WIDTH-1:0] sat      [NUM_STATES];
   logic [NUM_STATES-1:0]   sel;
   logic                    all_high;
   logic [1:0]              best_idx;

   // S0/S1 are reached from (S1,S3); S2/S3 from (S0,S2).
   function automatic int first_pred(input int s);
      return (s < 2) ? 1 : 0;
   endfunction

   function automatic int second_pred(input int s);
      return (s < 2) ? 3 : 2;
   endfunction

   // frame_start frees the busy window, so a coincident symbol starts the new frame.
   assign accept = bm_vld && (frame_start || busy == 2'd0);
   assign emit   = s1_vld && !frame_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 2'd0;
         fresh   <= 1'b1;
         s1_vld  <= 1'b0;
         sym_cnt <= 16'd0;
         overrun <= 1'b0;
      end else begin
         s1_vld <= accept;

         if (accept)
            busy <= 2'd2;
         else if (frame_start)
            busy <= 2'd0;
         else if (busy != 2'd0)
            busy <= busy - 2'd1;

         if (accept)
            fresh <= 1'b0;
         else if (frame_start)
            fresh <= 1'b1;

         if (frame_start)
            overrun <= 1'b0;
         else if (bm_vld && !accept)
            overrun <= 1'b1;

         if (frame_start)
            sym_cnt <= accept ? 16'd1 : 16'd0;
         else if (accept && sym_cnt != 16'hFFFF)
            sym_cnt <= sym_cnt + 16'd1;
      end
   end

   // A fresh trellis (or a frame starting this cycle) ignores the stored metrics.
   always_comb begin
      for (int s = 0; s < NUM_STATES; s++) begin
         pm_use[s] = (fresh || frame_start) ? '0 : pm_in[s*METRIC_WIDTH +: METRIC_WIDTH];
      end
      for (int s = 0; s < NUM_STATES; s++) begin
         cand_a_d[s] = {1'b0, pm_use[first_pred(s)]}  + SW'(bm_in[s*BM_WIDTH +: BM_WIDTH]);
         cand_b_d[s] = {1'b0, pm_use[second_pred(s)]} + SW'(bm_in[s*BM_WIDTH +: BM_WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            cand_a[s] <= '0;
            cand_b[s] <= '0;
         end
      end else if (accept) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            cand_a[s] <= cand_a_d[s];
            cand_b[s] <= cand_b_d[s];
         end
      end
   end

   // Ties keep the first predecessor; normalization only when every state is in the upper half.
   always_comb begin
      all_high = 1'b1;
      for (int s = 0; s < NUM_STATES; s++) begin
         sel[s]  = cand_b[s] > cand_a[s];
         surv[s] = sel[s] ? cand_b[s] : cand_a[s];
         if (surv[s] < HALF)
            all_high = 1'b0;
      end
      for (int s = 0; s < NUM_STATES; s++) begin
         norm[s] = all_high ? (surv[s] - HALF) : surv[s];
         sat[s]  = (norm[s] > {1'b0, MAXV}) ? MAXV : norm[s][METRIC_WIDTH-1:0];
      end
      best_idx = 2'd0;
      for (int s = 1; s < NUM_STATES; s++) begin
         if (sat[s] > sat[best_idx])
            best_idx = 2'(s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pm_new     <= '0;
         pm_vld     <= 1'b0;
         dec        <= '0;
         dec_vld    <= 1'b0;
         best_state <= 2'd0;
      end else begin
         pm_vld  <= emit;
         dec_vld <= emit;
         if (emit) begin
            for (int s = 0; s < NUM_STATES; s++) begin
               pm_new[s*METRIC_WIDTH +: METRIC_WIDTH] <= sat[s];
            end
            dec        <= sel;
            best_state <= best_idx;
         end
      end
   end

endmodule

// File: tb/tb_fm0_acsu.sv
// Directed testbench for fm0_acsu: expected results are queued when a symbol
// is driven and compared when the unit strobes pm_vld.
module tb_fm0_acsu;

   localparam int MW = 10;
   localparam int BW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          bm_vld;
   logic [4*BW-1:0] bm_in;
   logic          frame_start;
   logic [4*MW-1:0] pm_in;
   logic [4*MW-1:0] pm_new;
   logic          pm_vld;
   logic [3:0]    dec;
   logic          dec_vld;
   logic [1:0]    best_state;
   logic [15:0]   sym_cnt;
   logic          overrun;

   typedef struct packed {
      logic [4*MW-1:0] pm;
      logic [3:0]      dcs;
      logic [1:0]      best;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic prev_vld = 1'b0;

   fm0_acsu #(.METRIC_WIDTH(MW), .BM_WIDTH(BW), .NUM_STATES(4)) dut (
      .clk(clk), .rst(rst), .bm_vld(bm_vld), .bm_in(bm_in),
      .frame_start(frame_start), .pm_in(pm_in), .pm_new(pm_new),
      .pm_vld(pm_vld), .dec(dec), .dec_vld(dec_vld),
      .best_state(best_state), .sym_cnt(sym_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [4*MW-1:0] pk_pm(input int a0, input int a1, input int a2, input int a3);
      return {MW'(a3), MW'(a2), MW'(a1), MW'(a0)};
   endfunction

   function automatic logic [4*BW-1:0] pk_bm(input int a0, input int a1, input int a2, input int a3);
      return {BW'(a3), BW'(a2), BW'(a1), BW'(a0)};
   endfunction

   function automatic exp_t mk(input logic [4*MW-1:0] pm, input logic [3:0] d, input logic [1:0] b);
      exp_t e;
      e.pm = pm; e.dcs = d; e.best = b;
      return e;
   endfunction

   // Reference ACS built straight from the trellis table.
   function automatic exp_t model(input logic [4*MW-1:0] pm, input logic [4*BW-1:0] bm);
      int p[4]; int b[4]; int n[4];
      int fp[4] = '{1, 1, 0, 0};
      int sp[4] = '{3, 3, 2, 2};
      int hi;
      exp_t e;
      e = '0;
      for (int s = 0; s < 4; s++) begin
         p[s] = int'(pm[s*MW +: MW]);
         b[s] = int'(bm[s*BW +: BW]);
      end
      hi = 1;
      for (int s = 0; s < 4; s++) begin
         if (p[sp[s]] + b[s] > p[fp[s]] + b[s]) begin
            n[s] = p[sp[s]] + b[s];
            e.dcs[s] = 1'b1;
         end else begin
            n[s] = p[fp[s]] + b[s];
         end
         if (n[s] < 512) hi = 0;
      end
      for (int s = 0; s < 4; s++) begin
         if (hi != 0) n[s] = n[s] - 512;
         if (n[s] > 1023) n[s] = 1023;
         e.pm[s*MW +: MW] = MW'(n[s]);
      end
      for (int s = 3; s >= 0; s--) begin
         if (n[s] >= int'(e.pm[e.best*MW +: MW])) e.best = 2'(s);
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic [4*MW-1:0] pm, input logic [4*BW-1:0] bm,
                                input bit fs, input bit push, input exp_t e);
      pm_in = pm; bm_in = bm; bm_vld = 1'b1; frame_start = fs;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      bm_vld = 1'b0; frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && (pm_vld === 1'b1 || dec_vld === 1'b1)) begin
         exp_t e;
         check("vld_pair", {63'd0, dec_vld}, {63'd0, pm_vld});
         check("strobe_width", {63'd0, prev_vld}, 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("pm_new", {24'd0, pm_new}, {24'd0, e.pm});
            check("dec", {60'd0, dec}, {60'd0, e.dcs});
            check("best_state", {62'd0, best_state}, {62'd0, e.best});
         end
      end
      prev_vld = pm_vld;
   end

   initial begin
      exp_t e;
      logic [4*MW-1:0] rp;
      logic [4*BW-1:0] rb;
      rst = 1'b1; bm_vld = 1'b0; frame_start = 1'b0; bm_in = '0; pm_in = '0;
      idle(2);
      @(negedge clk);
      check("rst_pm_new", {24'd0, pm_new}, 64'd0);
      check("rst_pm_vld", {63'd0, pm_vld}, 64'd0);
      check("rst_dec", {60'd0, dec}, 64'd0);
      check("rst_dec_vld", {63'd0, dec_vld}, 64'd0);
      check("rst_best", {62'd0, best_state}, 64'd0);
      check("rst_sym_cnt", {48'd0, sym_cnt}, 64'd0);
      check("rst_overrun", {63'd0, overrun}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // First symbol after reset ignores pm_in.
      applyStimulus(pk_pm(999, 999, 999, 999), pk_bm(40, 20, 10, 5), 1'b0, 1'b1,
                    mk(pk_pm(40, 20, 10, 5), 4'b0000, 2'd0));
      idle(3);
      check("cnt_after_first", {48'd0, sym_cnt}, 64'd1);

      applyStimulus(pk_pm(10, 5, 40, 20), pk_bm(1, 2, 3, 4), 1'b0, 1'b1,
                    mk(pk_pm(21, 22, 43, 44), 4'b1111, 2'd3));
      idle(3);

      applyStimulus(pk_pm(600, 590, 580, 570), pk_bm(0, 0, 0, 0), 1'b0, 1'b1,
                    mk(pk_pm(78, 78, 88, 88), 4'b0000, 2'd2));
      idle(3);
      check("cnt_after_norm", {48'd0, sym_cnt}, 64'd3);
      check("no_overrun_yet", {63'd0, overrun}, 64'd0);

      // Back-to-back bm_vld: second is dropped, E+3 is accepted.
      applyStimulus(pk_pm(400, 200, 100, 300), pk_bm(5, 6, 7, 8), 1'b0, 1'b1,
                    mk(pk_pm(305, 306, 407, 408), 4'b0011, 2'd3));
      applyStimulus(pk_pm(1, 2, 3, 4), pk_bm(63, 63, 63, 63), 1'b0, 1'b0, '0);
      idle(1);
      applyStimulus(pk_pm(50, 30, 70, 30), pk_bm(0, 1, 3, 3), 1'b0, 1'b1,
                    mk(pk_pm(30, 31, 73, 73), 4'b1100, 2'd2));
      idle(3);
      check("overrun_set", {63'd0, overrun}, 64'd1);
      check("cnt_after_overrun", {48'd0, sym_cnt}, 64'd5);

      for (int i = 0; i < 4; i++) begin
         rp = pk_pm($urandom_range(1023), $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
         rb = pk_bm($urandom_range(63), $urandom_range(63), $urandom_range(63), $urandom_range(63));
         applyStimulus(rp, rb, 1'b0, 1'b1, model(rp, rb));
         idle(3);
      end
      check("overrun_sticky", {63'd0, overrun}, 64'd1);

      // frame_start one cycle after a symbol squashes it.
      applyStimulus(pk_pm(100, 100, 100, 100), pk_bm(9, 9, 9, 9), 1'b0, 1'b0, '0);
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      check("fs_cnt_clear", {48'd0, sym_cnt}, 64'd0);
      check("fs_overrun_clear", {63'd0, overrun}, 64'd0);
      idle(3);
      applyStimulus(pk_pm(500, 400, 300, 200), pk_bm(7, 9, 9, 3), 1'b0, 1'b1,
                    mk(pk_pm(7, 9, 9, 3), 4'b0000, 2'd1));
      idle(3);
      check("fs_cnt_one", {48'd0, sym_cnt}, 64'd1);
      rp = pk_pm(10, 20, 30, 40);
      rb = pk_bm(4, 3, 2, 1);
      applyStimulus(rp, rb, 1'b0, 1'b1, model(rp, rb));
      idle(3);
      check("cnt_two", {48'd0, sym_cnt}, 64'd2);
      applyStimulus(pk_pm(800, 800, 800, 800), pk_bm(12, 3, 12, 63), 1'b1, 1'b1,
                    mk(pk_pm(12, 3, 12, 63), 4'b0000, 2'd3));
      idle(3);
      check("fs_coincident_cnt", {48'd0, sym_cnt}, 64'd1);

      // Reset with a symbol in flight.
      applyStimulus(pk_pm(100, 200, 300, 400), pk_bm(1, 2, 3, 4), 1'b0, 1'b0, '0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_pm_new", {24'd0, pm_new}, 64'd0);
      check("mid_rst_pm_vld", {63'd0, pm_vld}, 64'd0);
      check("mid_rst_dec", {60'd0, dec}, 64'd0);
      check("mid_rst_best", {62'd0, best_state}, 64'd0);
      check("mid_rst_cnt", {48'd0, sym_cnt}, 64'd0);
      idle(3);
      applyStimulus(pk_pm(900, 900, 900, 900), pk_bm(5, 33, 2, 33), 1'b0, 1'b1,
                    mk(pk_pm(5, 33, 2, 33), 4'b0000, 2'd1));
      idle(5);
      check("cnt_after_rst", {48'd0, sym_cnt}, 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
